// File: rtl/sd_pixel_packer.sv
// Packs SD byte stream into RGB444 words for one of four image slots; skips a fixed header.
// Latency: RAM write one cycle after the second byte of a pair; done two cycles after the last byte.
// No backpressure: accepts a byte every cycle; start while busy and bytes while idle are dropped.
module sd_pixel_packer #(
    parameter int IMG_PIXELS = 19200,
    parameter int HDR_BYTES  = 0,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        image_select,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_write_en,
    output logic              busy,
    output logic              done,
    output logic [3:0]        loaded
);

    typedef enum logic [2:0] {IDLE, SKIP, LO, HI, DONE} state_t;

    localparam logic [ADDR_W-1:0] PIX_W    = ADDR_W'(IMG_PIXELS);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [15:0]       HDR_LAST = 16'((HDR_BYTES > 0) ? (HDR_BYTES - 1) : 0);

    state_t            state;
    logic [1:0]        slot;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] pix_cnt;
    logic [15:0]       skip_cnt;
    logic [7:0]        lo_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot         <= 2'd0;
            base         <= '0;
            pix_cnt      <= '0;
            skip_cnt     <= 16'd0;
            lo_byte      <= 8'd0;
            ram_addr     <= '0;
            ram_data     <= 16'd0;
            ram_write_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            loaded       <= 4'b0000;
        end else begin
            ram_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // A byte arriving alongside start is intentionally dropped.
                    if (start) begin
                        slot                 <= image_select;
                        base                 <= ADDR_W'(image_select) * PIX_W;
                        pix_cnt              <= '0;
                        skip_cnt             <= 16'd0;
                        loaded[image_select] <= 1'b0;
                        busy                 <= 1'b1;
                        state                <= (HDR_BYTES > 0) ? SKIP : LO;
                    end
                end
                SKIP: begin
                    if (data_valid) begin
                        skip_cnt <= skip_cnt + 16'd1;
                        if (skip_cnt == HDR_LAST) begin
                            state <= LO;
                        end
                    end
                end
                LO: begin
                    if (data_valid) begin
                        lo_byte <= data_in;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (data_valid) begin
                        ram_data     <= {data_in, lo_byte};
                        ram_addr     <= base + pix_cnt;
                        ram_write_en <= 1'b1;
                        pix_cnt      <= pix_cnt + 1'b1;
                        state        <= (pix_cnt == PIX_LAST) ? DONE : LO;
                    end
                end
                DONE: begin
                    // Two cycles here: the last write drains, then done/loaded are presented.
                    if (!done) begin
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        loaded[slot] <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_pixel_packer.sv
// Three packer instances (small, headered, full-size) checked against a byte-level load model.
module tb_sd_pixel_packer;

    localparam int PIX_P [3] = '{4, 2, 19200};
    localparam int HDR_P [3] = '{0, 3, 0};

    logic        clk = 1'b0;
    logic        rst_n        [3];
    logic        start        [3];
    logic [1:0]  image_select [3];
    logic [7:0]  data_in      [3];
    logic        data_valid   [3];
    logic [16:0] ram_addr     [3];
    logic [15:0] ram_data     [3];
    logic        ram_write_en [3];
    logic        busy         [3];
    logic        done         [3];
    logic [3:0]  loaded       [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_pixel_packer #(
            .IMG_PIXELS ((g == 0) ? 4 : (g == 1) ? 2 : 19200),
            .HDR_BYTES  ((g == 1) ? 3 : 0),
            .ADDR_W     (17)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .start        (start[g]),
            .image_select (image_select[g]),
            .data_in      (data_in[g]),
            .data_valid   (data_valid[g]),
            .ram_addr     (ram_addr[g]),
            .ram_data     (ram_data[g]),
            .ram_write_en (ram_write_en[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .loaded       (loaded[g])
        );
    end

    typedef struct {
        int          k;
        logic [16:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        dv;
        logic [7:0]  b;
        logic        exp_we;
        logic [16:0] exp_addr;
        logic [15:0] exp_data;
        logic        exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Load model: what each instance should be doing, in terms of bytes and pixels.
    wr_t        expq[$];
    logic       active    [3];
    logic [1:0] slot_m    [3];
    logic [3:0] loaded_m  [3];
    int         nbytes    [3];
    int         pix_done  [3];
    logic       have_lo   [3];
    logic [7:0] lo_m      [3];
    int         done_cyc  [3];
    int         ready_cyc [3];
    int         done_seen [3];

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, k, cyc, got, want);
        end
    endtask

    task automatic model_clear(input int k);
        active[k]    = 1'b0;
        loaded_m[k]  = 4'b0000;
        done_cyc[k]  = -1;
        ready_cyc[k] = 0;
        have_lo[k]   = 1'b0;
        expq.delete();
    endtask

    task automatic model_byte(input int k, input logic [7:0] b);
        if (!active[k] || pix_done[k] >= PIX_P[k]) return;
        if (nbytes[k] < HDR_P[k]) begin
            nbytes[k]++;
        end else if (!have_lo[k]) begin
            lo_m[k]    = b;
            have_lo[k] = 1'b1;
        end else begin
            expq.push_back('{k, 17'(int'(slot_m[k]) * PIX_P[k] + pix_done[k]), {b, lo_m[k]}, cyc + 1});
            pix_done[k]++;
            have_lo[k] = 1'b0;
            if (pix_done[k] == PIX_P[k]) done_cyc[k] = cyc + 2;
        end
    endtask

    task automatic monitor(input int k);
        logic exp_done;
        wr_t  e;
        exp_done = (cyc == done_cyc[k]);
        if (exp_done) begin
            active[k]               = 1'b0;
            loaded_m[k][slot_m[k]]  = 1'b1;
            ready_cyc[k]            = cyc + 2;
            done_cyc[k]             = -1;
        end
        if (ram_write_en[k]) begin
            if (expq.size() == 0 || expq[0].k != k) begin
                chk("unexpected_write", k, 32'(ram_addr[k]), 32'h1ffff);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", k, 32'(ram_addr[k]), 32'(e.addr));
                chk("wr_data", k, 32'(ram_data[k]), 32'(e.data));
                chk("wr_cycle", k, 32'(cyc), 32'(e.cyc));
            end
        end else if (expq.size() > 0 && expq[0].k == k && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            chk("missing_write", k, 32'(0), 32'(e.addr));
        end
        if (done[k]) done_seen[k]++;
        chk("done", k, 32'(done[k]), 32'(exp_done));
        chk("busy", k, 32'(busy[k]), 32'(active[k]));
        chk("loaded", k, 32'(loaded[k]), 32'(loaded_m[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) monitor(k);
    endtask

    task automatic feed(input int k, input logic [7:0] b);
        data_valid[k] = 1'b1;
        data_in[k]    = b;
        model_byte(k, b);
        tick();
        data_valid[k] = 1'b0;
    endtask

    task automatic do_start(input int k, input logic [1:0] sel, input logic dv, input logic [7:0] b);
        start[k]        = 1'b1;
        image_select[k] = sel;
        data_valid[k]   = dv;
        data_in[k]      = b;
        if (active[k]) begin
            if (dv) model_byte(k, b);
        end else if (cyc + 1 >= ready_cyc[k]) begin
            active[k]           = 1'b1;
            slot_m[k]           = sel;
            nbytes[k]           = 0;
            pix_done[k]         = 0;
            have_lo[k]          = 1'b0;
            loaded_m[k][sel]    = 1'b0;
        end
        tick();
        start[k]      = 1'b0;
        data_valid[k] = 1'b0;
    endtask

    task automatic run_to_done(input int k);
        int budget;
        budget = 0;
        while (active[k] && budget < 400) begin
            if ($urandom_range(0, 3) == 0) tick();
            else feed(k, 8'($urandom));
            budget++;
        end
        chk("load_timeout", k, 32'(active[k]), 32'(0));
    endtask

    task automatic assert_reset_check(input int k);
        rst_n[k] = 1'b0;
        #1;
        model_clear(k);
        chk("rst_addr", k, 32'(ram_addr[k]), 32'(0));
        chk("rst_data", k, 32'(ram_data[k]), 32'(0));
        chk("rst_we", k, 32'(ram_write_en[k]), 32'(0));
        chk("rst_busy", k, 32'(busy[k]), 32'(0));
        chk("rst_done", k, 32'(done[k]), 32'(0));
        chk("rst_loaded", k, 32'(loaded[k]), 32'(0));
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 8'h01, 1'b0, 17'd0,  16'h0000, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b1, 17'd8,  16'h0201, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 17'd0,  16'h0000, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 1'b1, 17'd9,  16'h0403, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 17'd0,  16'h0000, 1'b0};
        vecs[5] = '{1'b1, 8'h06, 1'b1, 17'd10, 16'h0605, 1'b0};
        vecs[6] = '{1'b1, 8'h07, 1'b0, 17'd0,  16'h0000, 1'b0};
        vecs[7] = '{1'b1, 8'h08, 1'b1, 17'd11, 16'h0807, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 17'd0,  16'h0000, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 17'd0,  16'h0000, 1'b0};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; image_select[k] = 2'd0;
            data_in[k] = 8'd0; data_valid[k] = 1'b0; done_seen[k] = 0;
            model_clear(k);
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) assert_reset_check(k);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();

        // Back-to-back load of slot 2, compared row by row.
        do_start(0, 2'd2, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].dv) feed(0, vecs[i].b);
            else tick();
            chk("vec_we", i, 32'(ram_write_en[0]), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk("vec_addr", i, 32'(ram_addr[0]), 32'(vecs[i].exp_addr));
                chk("vec_data", i, 32'(ram_data[0]), 32'(vecs[i].exp_data));
            end
            chk("vec_done", i, 32'(done[0]), 32'(vecs[i].exp_done));
        end
        chk("t1_loaded", 0, 32'(loaded[0]), 32'(4'b0100));

        // Header skip with gaps: AA BB CC discarded, slot 1 gets 0x2211, 0x4433.
        do_start(1, 2'd1, 1'b0, 8'h00);
        begin
            logic [7:0] hb [7];
            hb = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44};
            for (int i = 0; i < 7; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                feed(1, hb[i]);
            end
        end
        repeat (3) tick();
        chk("t2_loaded", 1, 32'(loaded[1]), 32'(4'b0010));

        // Idle bytes ignored, start while busy ignored.
        feed(0, 8'h5A); feed(0, 8'hA5); tick();
        do_start(0, 2'd1, 1'b0, 8'h00);
        feed(0, 8'h10); feed(0, 8'h20);
        do_start(0, 2'd3, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) feed(0, 8'(8'h30 + i));
        repeat (3) tick();
        chk("t3_loaded", 0, 32'(loaded[0]), 32'(4'b0110));

        // Start with a byte in the same cycle: that byte is dropped.
        do_start(0, 2'd0, 1'b1, 8'hEE);
        feed(0, 8'h10); feed(0, 8'h20);
        chk("t4_addr", 0, 32'(ram_addr[0]), 32'(0));
        chk("t4_data", 0, 32'(ram_data[0]), 32'(16'h2010));
        for (int i = 0; i < 6; i++) feed(0, 8'(i));
        repeat (3) tick();

        // Reset after one pixel, then a fresh load of slot 3.
        do_start(0, 2'd2, 1'b0, 8'h00);
        feed(0, 8'h77); feed(0, 8'h88); feed(0, 8'h99);
        assert_reset_check(0);
        tick();
        rst_n[0] = 1'b1;
        tick();
        do_start(0, 2'd3, 1'b0, 8'h00);
        run_to_done(0);
        repeat (2) tick();
        chk("t5_loaded", 0, 32'(loaded[0]), 32'(4'b1000));

        // Randomised loads, gaps, stray starts and idle bytes on both small instances.
        for (int it = 0; it < 30; it++) begin
            int k;
            k = $urandom_range(0, 1);
            repeat (2) tick();
            if ($urandom_range(0, 1) == 1) feed(k, 8'($urandom));
            do_start(k, 2'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) do_start(k, 2'($urandom), 1'($urandom), 8'($urandom));
            run_to_done(k);
        end
        repeat (3) tick();

        // Full-size image into slot 3, bytes every cycle.
        do_start(2, 2'd3, 1'b0, 8'h00);
        for (int i = 0; i < 38400; i++) feed(2, 8'($urandom));
        repeat (3) tick();
        chk("big_done_count", 2, 32'(done_seen[2]), 32'(1));
        chk("big_loaded", 2, 32'(loaded[2]), 32'(4'b1000));
        chk("queue_drained", 0, 32'(expq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
